// File: rtl/sm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sm_ctrl_pkg
// Shared definitions for the Simple RISC Machine control path: FSM state
// enum, opcode/op field encodings, register-select (nsel) and writeback
// source (vsel) codes, the bundled strobe vector produced by the output
// decoder, and helpers to convert between binary and one-hot state forms.
// Also used by the instruction decoder and the datapath.
// ---------------------------------------------------------------------------
package sm_ctrl_pkg;

    localparam int NUM_STATES = 8;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WR_REG = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    // instreg[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // instreg[12:11]
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    // One-hot register select fed back to the decoder
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    // Writeback mux source
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       illegal;
    } strobes_t;

    function automatic logic [NUM_STATES-1:0] st2oh(input state_e st);
        logic [NUM_STATES-1:0] v;
        v     = '0;
        v[st] = 1'b1;
        return v;
    endfunction

    // An all-zero vector (never produced in normal operation) decodes to WAIT.
    function automatic state_e oh2st(input logic [NUM_STATES-1:0] oh);
        state_e st;
        st = S_WAIT;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (oh[i]) begin
                st = state_e'(i[2:0]);
            end
        end
        return st;
    endfunction

endpackage

// File: rtl/sm_ctrl_outdec.sv
// ---------------------------------------------------------------------------
// sm_ctrl_outdec
// Combinational Moore output decoder: maps an FSM state plus the latched
// instruction fields to the full datapath strobe vector.
// Ports:
//   state   in  FSM state
//   opcode  in  latched instreg[15:13]
//   op      in  latched instreg[12:11]
//   strobes out strobe bundle (w, nsel, loads, selects, write, illegal)
// Optional: SM_ILLEGAL_TRAP_EN adds the HALT decode (illegal=1).
// ---------------------------------------------------------------------------
module sm_ctrl_outdec
    import sm_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output strobes_t   strobes
);

    always_comb begin
        strobes = '0;
        case (state)
            S_WAIT: begin
                strobes.w = 1'b1;
            end
            S_WR_IMM: begin
                strobes.nsel  = NSEL_RN;
                strobes.vsel  = VSEL_IMM;
                strobes.write = 1'b1;
            end
            S_GET_A: begin
                strobes.nsel  = NSEL_RN;
                strobes.loada = 1'b1;
            end
            S_GET_B: begin
                strobes.nsel  = NSEL_RM;
                strobes.loadb = 1'b1;
            end
            S_EXEC: begin
                strobes.loadc = 1'b1;
                // Single-operand instructions pass B through with A forced to 0
                strobes.asel  = ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
                                ((opcode == OPC_ALU) && (op == OP_MVN));
                strobes.loads = (opcode == OPC_ALU) && (op == OP_CMP);
            end
            S_WR_REG: begin
                strobes.nsel  = NSEL_RD;
                strobes.vsel  = VSEL_C;
                strobes.write = 1'b1;
            end
`ifdef SM_ILLEGAL_TRAP_EN
            S_HALT: begin
                strobes.illegal = 1'b1;
            end
`endif
            default: begin
                // DECODE asserts nothing
            end
        endcase
    end

endmodule

// File: rtl/sm_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// sm_ctrl_fsm
// Moore control FSM for the Simple RISC Machine datapath. Runs one
// instruction per start pulse and reports idle on w.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (returns to WAIT)
//   s        in   start, sampled only in WAIT
//   opcode   in   instreg[15:13]
//   op       in   instreg[12:11]
//   w        out  idle in WAIT
//   nsel     out  one-hot register select (001 Rn, 010 Rd, 100 Rm)
//   loada/loadb/loadc/loads  out  datapath register loads
//   asel     out  ALU A input forced to zero
//   bsel     out  ALU B input = sximm5 (always 0)
//   vsel     out  writeback source
//   write    out  register file write enable
//   illegal  out  undefined-instruction flag
// Parameter ONEHOT selects binary (0) or one-hot (1) state storage.
// Optional: define SM_ILLEGAL_TRAP_EN to trap undefined encodings in HALT.
// ---------------------------------------------------------------------------
module sm_ctrl_fsm
    import sm_ctrl_pkg::*;
#(
    parameter bit ONEHOT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       illegal
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] opc_q;
    logic [2:0] opc_d;
    logic [1:0] op_q;
    logic [1:0] op_d;
    strobes_t   strobes_d;
    strobes_t   strobes_q;

    // Next state and instruction-field latch
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        op_d    = op_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                    opc_d   = opcode;
                    op_d    = op;
                end
            end
            S_DECODE: begin
                if ((opc_q == OPC_MOV) && (op_q == OP_MOV_IMM)) begin
                    state_d = S_WR_IMM;
                end else if (((opc_q == OPC_MOV) && (op_q == OP_MOV_REG)) ||
                             ((opc_q == OPC_ALU) && (op_q == OP_MVN))) begin
                    state_d = S_GET_B;
                end else if (opc_q == OPC_ALU) begin
                    // Remaining ALU ops (ADD, CMP, AND) need both operands
                    state_d = S_GET_A;
                end else begin
`ifdef SM_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WR_IMM: state_d = S_WAIT;
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC: begin
                // CMP only updates flags, so it skips writeback
                if ((opc_q == OPC_ALU) && (op_q == OP_CMP)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG: state_d = S_WAIT;
`ifdef SM_ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so that the registered strobes
    // line up with the registered state (pure Moore timing, no glitches).
    sm_ctrl_outdec u_outdec (
        .state   (state_d),
        .opcode  (opc_d),
        .op      (op_d),
        .strobes (strobes_d)
    );

    generate
        if (ONEHOT) begin : g_onehot
            logic [NUM_STATES-1:0] state_oh_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_oh_q <= st2oh(S_WAIT);
                end else begin
                    state_oh_q <= st2oh(state_d);
                end
            end
            assign state_q = oh2st(state_oh_q);
        end else begin : g_binary
            state_e state_bin_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_bin_q <= S_WAIT;
                end else begin
                    state_bin_q <= state_d;
                end
            end
            assign state_q = state_bin_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opc_q       <= '0;
            op_q        <= '0;
            strobes_q   <= '0;
            strobes_q.w <= 1'b1;
        end else begin
            opc_q     <= opc_d;
            op_q      <= op_d;
            strobes_q <= strobes_d;
        end
    end

    assign w       = strobes_q.w;
    assign nsel    = strobes_q.nsel;
    assign loada   = strobes_q.loada;
    assign loadb   = strobes_q.loadb;
    assign loadc   = strobes_q.loadc;
    assign loads   = strobes_q.loads;
    assign asel    = strobes_q.asel;
    assign bsel    = strobes_q.bsel;
    assign vsel    = strobes_q.vsel;
    assign write   = strobes_q.write;
    assign illegal = strobes_q.illegal;

endmodule

// File: tb/tb_sm_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_sm_ctrl_fsm
// Self-checking bench for sm_ctrl_fsm. A per-instruction table model lists
// the expected output vector for every cycle after the start edge; random
// instructions and directed scenarios are compared against it cycle by cycle.
// Output vector layout: {w, nsel[2:0], loada, loadb, loadc, loads, asel,
// bsel, vsel[1:0], write, illegal}.
// ---------------------------------------------------------------------------
module tb_sm_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];
    logic [13:0] obs;

    sm_ctrl_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .nsel    (nsel),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .vsel    (vsel),
        .write   (write),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    assign obs = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal};

    function automatic logic [13:0] vec(input logic w_v, input logic [2:0] ns,
                                        input logic la, input logic lb, input logic lc,
                                        input logic ls, input logic as_v,
                                        input logic [1:0] vs, input logic wr,
                                        input logic il);
        return {w_v, ns, la, lb, lc, ls, as_v, 1'b0, vs, wr, il};
    endfunction

    function automatic bit is_defined(input logic [2:0] opc, input logic [1:0] o);
        if (opc == 3'b110) return (o == 2'b10) || (o == 2'b00);
        if (opc == 3'b101) return 1'b1;
        return 1'b0;
    endfunction

    // Expected per-cycle outputs, starting with the cycle after the start edge.
    function automatic void build(input logic [2:0] opc, input logic [1:0] o);
        logic [13:0] idle_v;
        logic [13:0] dec_v;
        logic [13:0] geta_v;
        logic [13:0] getb_v;
        logic [13:0] wrreg_v;
        idle_v  = vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        dec_v   = vec(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        geta_v  = vec(0, 3'b001, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        getb_v  = vec(0, 3'b100, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        wrreg_v = vec(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        exp_q.delete();
        exp_q.push_back(dec_v);
        if (opc == 3'b110 && o == 2'b10) begin
            exp_q.push_back(vec(0, 3'b001, 0, 0, 0, 0, 0, 2'b10, 1, 0));
        end else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
            exp_q.push_back(getb_v);
            exp_q.push_back(vec(0, 3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 0));
            exp_q.push_back(wrreg_v);
        end else if (opc == 3'b101 && o == 2'b01) begin
            exp_q.push_back(geta_v);
            exp_q.push_back(getb_v);
            exp_q.push_back(vec(0, 3'b000, 0, 0, 1, 1, 0, 2'b00, 0, 0));
        end else if (opc == 3'b101) begin
            exp_q.push_back(geta_v);
            exp_q.push_back(getb_v);
            exp_q.push_back(vec(0, 3'b000, 0, 0, 1, 0, 0, 2'b00, 0, 0));
            exp_q.push_back(wrreg_v);
        end else begin
`ifdef SM_ILLEGAL_TRAP_EN
            exp_q.push_back(vec(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1));
            return;
`endif
        end
        exp_q.push_back(idle_v);
    endfunction

    // Starts one instruction (DUT must be idle, called just after a negedge)
    // and checks every cycle until it is idle again. keep_s leaves s high so
    // the final idle cycle doubles as the next start.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                             input bit keep_s, input string name);
        build(opc, o);
        s      = 1'b1;
        opcode = opc;
        op     = o;
        @(posedge clk);
        #1;
        s      = keep_s;
        opcode = 3'($urandom);   // instreg changes must not matter mid-instruction
        op     = 2'($urandom);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL %s step %0d: got %b want %b", name, i, obs, exp_q[i]);
            end
            total++;
            if (($countones({loada, loadb, loadc, write}) > 1) || (write && loads)) begin
                bad++;
                $display("FAIL %s_exclusive step %0d: got la/lb/lc/wr/ls=%b%b%b%b%b want at most one load, no write with loads",
                         name, i, loada, loadb, loadc, write, loads);
            end
        end
        $display("txn %s opcode=%b op=%b cycles=%0d", name, opc, o, exp_q.size());
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        s      = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        repeat (2) @(negedge clk);
        total++;
        if (obs !== vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
            bad++;
            $display("FAIL reset_held: got %b want %b", obs, vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs !== vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", obs, vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        end
        $display("txn reset idle=%b", obs);
    endtask

    task automatic test_mov_imm();
        run_instr(3'b110, 2'b10, 1'b0, "mov_imm");
    endtask

    task automatic test_add();
        run_instr(3'b101, 2'b00, 1'b0, "add");
    endtask

    task automatic test_cmp();
        run_instr(3'b101, 2'b01, 1'b0, "cmp");
    endtask

    task automatic test_back_to_back();
        run_instr(3'b101, 2'b11, 1'b1, "mvn_b2b");
        run_instr(3'b110, 2'b00, 1'b0, "mov_reg_b2b");
    endtask

    task automatic test_reset_mid_exec();
        s      = 1'b1;
        opcode = 3'b101;
        op     = 2'b00;
        @(posedge clk);
        #1;
        s = 1'b0;
        repeat (4) @(negedge clk);   // DECODE, GET_A, GET_B, EXEC
        total++;
        if (loadc !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_exec_pre: got loadc=%b want 1", loadc);
        end
        reset = 1'b1;
        #1;
        total++;
        if (obs !== vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
            bad++;
            $display("FAIL rst_mid_exec_async: got %b want %b", obs, vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
                bad++;
                $display("FAIL rst_mid_exec_idle step %0d: got %b want %b", i, obs, vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
            end
        end
        $display("txn reset_mid_exec w=%b write=%b", w, write);
    endtask

    task automatic test_undefined();
        run_instr(3'b111, 2'($urandom), 1'b0, "undefined");
`ifdef SM_ILLEGAL_TRAP_EN
        s = 1'b1;
        for (int i = 0; i < 10; i++) begin
            opcode = 3'($urandom);
            op     = 2'($urandom);
            @(negedge clk);
            total++;
            if (obs !== vec(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1)) begin
                bad++;
                $display("FAIL halt_hold step %0d: got %b want %b", i, obs, vec(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1));
            end
        end
        s     = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
            bad++;
            $display("FAIL halt_cleared: got %b want %b", obs, vec(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        end
        $display("txn halt_release illegal=%b", illegal);
`endif
    endtask

    task automatic test_random();
        logic [2:0] opc;
        logic [1:0] o;
        bit         keep;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       opc = 3'b110;
                1, 2:    opc = 3'b101;
                default: opc = 3'($urandom);
            endcase
            o = 2'($urandom);
`ifdef SM_ILLEGAL_TRAP_EN
            if (!is_defined(opc, o)) opc = 3'b101;
`endif
            keep = (n != 39) && ($urandom_range(0, 1) == 1);
            run_instr(opc, o, keep, is_defined(opc, o) ? "random" : "random_undef");
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        test_undefined();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_ctrl_fsm.md
Name: sm_ctrl_fsm

Overview:
Moore FSM that sequences the Simple RISC Machine datapath: register file, A/B/C registers, shifter/ALU, status register, writeback mux. It sits beside the instruction decoder and consumes opcode/op from the instruction register. It drives nsel back into the decoder, plus all datapath load/select/write strobes. It runs one instruction per `s` pulse and reports idle on `w`.

Parameters:
ONEHOT, 0, state encoding: 0 = binary, 1 = one-hot. Observable behaviour is identical for both values.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
s  in  1  start; sampled only in WAIT
opcode  in  3  instreg[15:13] from the decoder
op  in  2  instreg[12:11] from the decoder
w  out  1  1 = idle in WAIT, ready for `s`
nsel  out  3  one-hot register select to the decoder: 001 Rn, 010 Rd, 100 Rm, 000 none
loada  out  1  load register A
loadb  out  1  load register B
loadc  out  1  load register C
loads  out  1  load status flags
asel  out  1  1 = ALU A input forced to zero
bsel  out  1  1 = ALU B input = sximm5; always 0 here
vsel  out  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata
write  out  1  register file write enable
illegal  out  1  undefined-instruction flag; see Optional Feature

Behaviour:
- States: WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_REG, HALT (HALT exists only with the macro).
- Reset: state = WAIT, taking effect immediately and asynchronously, including mid-instruction. Reset values: w=1, nsel=000, vsel=00, illegal=0, all other strobes 0.
- Outputs are a pure function of state and latched {opcode, op}. No Mealy paths from `s`.
- On clk with state WAIT and s=1: latch opcode/op, go to DECODE. s=0 stays in WAIT. `s` in any other state is ignored.
- Latched opcode/op are held until the next start, so instreg changes mid-instruction have no effect.
- DECODE branches on the latched fields:
  - 110/10 (MOV imm) -> WR_IMM.
  - 110/00 (MOV reg) and 101/11 (MVN) -> GET_B.
  - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A.
  - Anything else -> WAIT, or HALT with the macro.
- Per-state outputs; unlisted outputs are 0:
  - WAIT: w=1.
  - DECODE: nothing asserted.
  - WR_IMM: nsel=001, vsel=10, write=1; next WAIT.
  - GET_A: nsel=001, loada=1; next GET_B.
  - GET_B: nsel=100, loadb=1; next EXEC.
  - EXEC: loadc=1. asel=1 for MOV reg and MVN. loads=1 only for CMP. Next: WAIT for CMP, WR_REG otherwise.
  - WR_REG: nsel=010, vsel=00, write=1; next WAIT.
- Latency is measured in clk edges from the edge that samples s=1 until w=1 again:
  - MOV imm: 3.
  - MOV reg, MVN, CMP: 5.
  - ADD, AND: 6.
  - Undefined opcode without the macro: 2.
- Exactly one of {loada, loadb, loadc, write} is 1 in any cycle, or none.
- write and loads are never 1 together. CMP never asserts write.
- s held high continuously: back-to-back instructions run; w=1 for exactly one cycle between them.

Optional Feature:
Macro SM_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode/op in DECODE goes to HALT. HALT holds illegal=1 and w=0, ignores s, and is left only by reset.
- Undefined: the HALT state is not built, undefined encodings return to WAIT, and illegal is tied to 0.

Decomposition:
- Package sm_ctrl_pkg holds:
  - the state enum;
  - opcode constants OPC_MOV=3'b110 and OPC_ALU=3'b101;
  - op constants for ADD/CMP/AND/MVN and MOV_IMM/MOV_REG;
  - NSEL_RN/RD/RM/NONE;
  - VSEL_C/PC/IMM/MDATA.
- Shared with instdec and the datapath.
- Sub-module sm_ctrl_outdec: combinational state + latched op -> strobe vector. The FSM top holds only the next-state logic and registers.

Test Plan:
- Reset asserted mid-EXEC of ADD -> same cycle: w=1, all strobes 0, nsel=000. After release, idle in WAIT with no write.
- MOV imm (opcode 110, op 10), s=1 one cycle -> the cycle after DECODE shows nsel=001, vsel=10, write=1. w=1 on the 3rd edge.
- ADD (101/00) -> strobe sequence (GET_A/GET_B/EXEC/WR_REG, beginning the cycle after DECODE): loada(nsel 001), loadb(nsel 100), loadc with asel=0, write(nsel 010, vsel 00). w=1 on the 6th edge.
- CMP (101/01) -> loads=1 with loadc=1 in EXEC, write never asserted. w=1 on the 5th edge.
- MVN (101/11), then MOV reg (110/00) back-to-back with s held high -> no loada in either, asel=1 in both EXEC cycles. w high exactly one cycle between them.
- opcode 111 -> w=1 after 2 edges, illegal=0. With SM_ILLEGAL_TRAP_EN: HALT, illegal=1, s ignored for 10 cycles, cleared only by reset.
